serializer_frame_arbiter: RTL and testbench

Round-robin scheduler that shares one SerializerVRTL instance among N_REQ parallel-frame producers. It grants one producer and forwards that producer's N_SAMPLES-word frame to the serializer's parallel input. It then holds the grant and counts the serializer's output beats until the whole frame has drained. While a frame drains, it tags the serial stream with the source channel id and pulses a frame-done strobe on the last beat.

---
 rtl/serializer_arb_pkg.sv | 27 ++
 rtl/serializer_frame_arbiter_rr_pick.sv | 41 ++++
 rtl/serializer_frame_arbiter.sv | 109 ++++++++++
 tb/tb_serializer_frame_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_arb_pkg.sv
// Shared types and width helpers for the serializer frame arbiter.
//   state_t      : arbiter FSM states (IDLE: offering a frame, DRAIN: counting beats)
//   chan_width() : channel-id / pointer width, never narrower than one bit
//   cnt_width()  : beat-counter width, wide enough to hold N_SAMPLES
package serializer_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int unsigned DEF_BIT_WIDTH = 32;
    localparam int unsigned DEF_N_SAMPLES = 8;
    localparam int unsigned DEF_N_REQ     = 4;

    function automatic int unsigned chan_width(input int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n_samples);
        return $clog2(n_samples) + 1;
    endfunction

    localparam int unsigned CHAN_W = chan_width(DEF_N_REQ);
    localparam int unsigned CNT_W  = cnt_width(DEF_N_SAMPLES);

endpackage

// File: rtl/serializer_frame_arbiter_rr_pick.sv
// Wrap-around find-first: returns the first set request at or after the
// pointer, wrapping modulo N_REQ.
//   i_req : request vector
//   i_ptr : search start position
//   o_any : at least one request is set
//   o_idx : index of the winning request (0 when o_any is low)
module rr_pick
    import serializer_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = DEF_N_REQ,
    localparam int unsigned IDX_W = chan_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx
);

    // (base + off) mod N_REQ, off < N_REQ and base < N_REQ
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return IDX_W'(sum);
    endfunction

    // Scan farthest to nearest so the candidate closest to the pointer wins.
    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (i_req[wrap_add(i_ptr, 32'(i))]) begin
                o_idx = wrap_add(i_ptr, 32'(i));
            end
        end
    end

endmodule

// File: rtl/serializer_frame_arbiter.sv
// Round-robin arbiter sharing one serializer among N_REQ frame producers.
// Offers the winning producer's frame to the serializer, then holds the grant
// while counting the serializer's output beats until the frame has drained.
//   clk, reset          : clock, async active-high reset
//   recv_msg/val/rdy    : per-producer parallel frames and handshake
//   ser_msg/val/rdy     : frame handshake toward the serializer input
//   mon_val/mon_rdy     : observed serializer output handshake
//   chan_id/chan_val    : source tag for the frame being drained
//   frame_done          : pulse on the last beat of a frame
//   grant               : one-hot grant
module serializer_frame_arbiter
    import serializer_arb_pkg::*;
#(
    parameter  int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
    parameter  int unsigned N_SAMPLES = DEF_N_SAMPLES,
    parameter  int unsigned N_REQ     = DEF_N_REQ,
    localparam int unsigned ID_W      = chan_width(N_REQ),
    localparam int unsigned CW        = cnt_width(N_SAMPLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg [N_REQ-1:0][N_SAMPLES-1:0],
    input  logic [N_REQ-1:0]     recv_val,
    output logic [N_REQ-1:0]     recv_rdy,
    output logic [BIT_WIDTH-1:0] ser_msg [N_SAMPLES-1:0],
    output logic                 ser_val,
    input  logic                 ser_rdy,
    input  logic                 mon_val,
    input  logic                 mon_rdy,
    output logic [ID_W-1:0]      chan_id,
    output logic                 chan_val,
    output logic                 frame_done,
    output logic [N_REQ-1:0]     grant
);

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [ID_W-1:0] r_chan_id;

    logic            w_pick_any;
    logic [ID_W-1:0] w_pick_idx;
    logic [ID_W-1:0] w_next_ptr;
    logic            w_accept;
    logic            w_beat;
    logic            w_last_beat;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .i_req (recv_val),
        .i_ptr (r_ptr),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

    // Pointer moves to the slot after the winner so it becomes lowest priority.
    assign w_next_ptr  = (w_pick_idx == ID_W'(N_REQ - 1)) ? '0 : w_pick_idx + ID_W'(1);
    assign w_accept    = (r_state == IDLE) && w_pick_any && ser_rdy;
    assign w_beat      = mon_val && mon_rdy;
    assign w_last_beat = w_beat && (r_cnt == CW'(N_SAMPLES - 1));
    assign chan_id     = r_chan_id;

    // Output decode from state and the current pick.
    always_comb begin
        grant      = '0;
        recv_rdy   = '0;
        ser_val    = 1'b0;
        chan_val   = 1'b0;
        frame_done = 1'b0;
        ser_msg    = recv_msg[w_pick_idx];
        if (r_state == IDLE) begin
            ser_val = w_pick_any;
            if (w_pick_any) begin
                grant[w_pick_idx]    = 1'b1;
                recv_rdy[w_pick_idx] = ser_rdy;
            end
        end else begin
            grant[r_chan_id] = 1'b1;
            chan_val         = 1'b1;
            frame_done       = w_last_beat;
        end
    end

    // Arbiter FSM; beats seen in IDLE are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_chan_id <= '0;
        end else if (r_state == IDLE) begin
            if (w_accept) begin
                r_chan_id <= w_pick_idx;
                r_ptr     <= w_next_ptr;
                r_cnt     <= '0;
                r_state   <= DRAIN;
            end
        end else if (w_beat) begin
            if (w_last_beat) begin
                r_cnt   <= '0;
                r_state <= IDLE;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serializer_frame_arbiter.sv
// Self-checking bench for serializer_frame_arbiter: a constant-vector table,
// directed multi-cycle sequences and a randomized run against a frame-level model.
module tb_serializer_frame_arbiter;
    import serializer_arb_pkg::*;

    localparam int unsigned BW = 32;
    localparam int unsigned NS = 8;
    localparam int unsigned NR = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [BW-1:0]     recv_msg [NR-1:0][NS-1:0];
    logic [NR-1:0]     recv_val = '0;
    logic [NR-1:0]     recv_rdy;
    logic [BW-1:0]     ser_msg [NS-1:0];
    logic              ser_val;
    logic              ser_rdy = 1'b0;
    logic              mon_val = 1'b0;
    logic              mon_rdy = 1'b0;
    logic [CHAN_W-1:0] chan_id;
    logic              chan_val;
    logic              frame_done;
    logic [NR-1:0]     grant;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: frame in flight, beats still owed, pointer, drained channel.
    int m_busy = 0;
    int m_left = 0;
    int m_ptr  = 0;
    int m_chan = 0;
    int fd_seen = 0;
    int fd_q[$];

    always #5 clk = ~clk;

    serializer_frame_arbiter #(
        .BIT_WIDTH (BW),
        .N_SAMPLES (NS),
        .N_REQ     (NR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .recv_msg   (recv_msg),
        .recv_val   (recv_val),
        .recv_rdy   (recv_rdy),
        .ser_msg    (ser_msg),
        .ser_val    (ser_val),
        .ser_rdy    (ser_rdy),
        .mon_val    (mon_val),
        .mon_rdy    (mon_rdy),
        .chan_id    (chan_id),
        .chan_val   (chan_val),
        .frame_done (frame_done),
        .grant      (grant)
    );

    typedef struct {
        logic [NR-1:0] rv;
        logic          sr;
        logic          mv;
        logic          mr;
        logic [NR-1:0] e_grant;
        logic [NR-1:0] e_rdy;
        logic          e_sv;
        logic          e_cv;
        logic [1:0]    e_cid;
        logic          e_fd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [NR-1:0] rv, input logic sr, input logic mv,
                                input logic mr, input logic [NR-1:0] g, input logic [NR-1:0] r,
                                input logic sv, input logic cv, input logic [1:0] cid,
                                input logic fd);
        vec_t v;
        v.rv = rv; v.sr = sr; v.mv = mv; v.mr = mr;
        v.e_grant = g; v.e_rdy = r; v.e_sv = sv; v.e_cv = cv; v.e_cid = cid; v.e_fd = fd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NR-1:0] rv, input logic sr, input logic mv, input logic mr);
        recv_val = rv;
        ser_rdy  = sr;
        mon_val  = mv;
        mon_rdy  = mr;
    endtask

    function automatic logic [255:0] frame_of(input int ch);
        logic [255:0] f;
        f = '0;
        for (int w = 0; w < int'(NS); w++) f[w*BW +: BW] = recv_msg[ch][w];
        return f;
    endfunction

    function automatic logic [255:0] ser_packed();
        logic [255:0] f;
        f = '0;
        for (int w = 0; w < int'(NS); w++) f[w*BW +: BW] = ser_msg[w];
        return f;
    endfunction

    // Closest requester at or after the pointer, by circular distance.
    function automatic int m_winner(input logic [NR-1:0] rv);
        int best;
        int bestd;
        best  = -1;
        bestd = int'(NR);
        for (int i = 0; i < int'(NR); i++) begin
            if (rv[i]) begin
                int d;
                d = (i - m_ptr + int'(NR)) % int'(NR);
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_left = 0; m_ptr = 0; m_chan = 0;
    endtask

    task automatic model_step();
        int w;
        w = m_winner(recv_val);
        if (m_busy == 0) begin
            if (w >= 0 && ser_rdy) begin
                m_busy = 1;
                m_left = int'(NS);
                m_chan = w;
                m_ptr  = (w + 1) % int'(NR);
            end
        end else if (mon_val && mon_rdy) begin
            m_left--;
            if (m_left == 0) m_busy = 0;
        end
    endtask

    task automatic check_model(input string tag);
        int w;
        logic [NR-1:0] eg;
        logic [NR-1:0] er;
        logic esv, ecv, efd;
        w  = m_winner(recv_val);
        eg = '0;
        er = '0;
        if (m_busy == 0) begin
            if (w >= 0) begin
                eg[w] = 1'b1;
                er[w] = ser_rdy;
            end
            esv = (w >= 0);
            ecv = 1'b0;
            efd = 1'b0;
        end else begin
            eg[m_chan] = 1'b1;
            esv = 1'b0;
            ecv = 1'b1;
            efd = mon_val && mon_rdy && (m_left == 1);
        end
        chk({tag, ".grant"}, 256'(grant), 256'(eg));
        chk({tag, ".recv_rdy"}, 256'(recv_rdy), 256'(er));
        chk({tag, ".ser_val"}, 256'(ser_val), 256'(esv));
        chk({tag, ".chan_val"}, 256'(chan_val), 256'(ecv));
        chk({tag, ".frame_done"}, 256'(frame_done), 256'(efd));
        chk({tag, ".chan_id"}, 256'(chan_id), 256'(m_chan));
        if (m_busy == 0 && w >= 0) chk({tag, ".ser_msg"}, ser_packed(), frame_of(w));
        if (frame_done === 1'b1) begin
            fd_seen++;
            fd_q.push_back(int'(chan_id));
        end
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        check_model(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int fd_at;
        int fd_before;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        for (int c = 0; c < int'(NR); c++)
            for (int w = 0; w < int'(NS); w++) recv_msg[c][w] = $urandom;

        // Reset, idle, one frame from channel 2, idle beat ignored, pointer at 3.
        repeat (5) tbl.push_back(mk(4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 0));
        tbl.push_back(mk(4'b0100, 1, 0, 0, 4'b0100, 4'b0100, 1, 0, 2'd0, 0));
        for (int b = 0; b < 8; b++)
            tbl.push_back(mk(4'b0000, 1, 1, 1, 4'b0100, 4'b0000, 0, 1, 2'd2, (b == 7)));
        tbl.push_back(mk(4'b0000, 1, 1, 1, 4'b0000, 4'b0000, 0, 0, 2'd2, 0));
        tbl.push_back(mk(4'b0001, 0, 1, 1, 4'b0001, 4'b0000, 1, 0, 2'd2, 0));
        tbl.push_back(mk(4'b1001, 0, 1, 1, 4'b1000, 4'b0000, 1, 0, 2'd2, 0));

        do_reset();
        foreach (tbl[k]) begin
            drive(tbl[k].rv, tbl[k].sr, tbl[k].mv, tbl[k].mr);
            @(negedge clk);
            chk($sformatf("tbl%0d.grant", k), 256'(grant), 256'(tbl[k].e_grant));
            chk($sformatf("tbl%0d.recv_rdy", k), 256'(recv_rdy), 256'(tbl[k].e_rdy));
            chk($sformatf("tbl%0d.ser_val", k), 256'(ser_val), 256'(tbl[k].e_sv));
            chk($sformatf("tbl%0d.chan_val", k), 256'(chan_val), 256'(tbl[k].e_cv));
            chk($sformatf("tbl%0d.chan_id", k), 256'(chan_id), 256'(tbl[k].e_cid));
            chk($sformatf("tbl%0d.frame_done", k), 256'(frame_done), 256'(tbl[k].e_fd));
            @(posedge clk);
            model_step();
            #1;
        end

        // All four requesting continuously: grants 0,1,2,3,0.
        do_reset();
        fd_q.delete();
        drive(4'b1111, 1, 1, 1);
        repeat (45) cycle("rr");
        chk("rr_fd_count", 256'(fd_q.size()), 256'(5));
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order%0d", k), (k < fd_q.size()) ? 256'(fd_q[k]) : '1,
                256'(exp_order[k]));

        // Downstream backpressure on alternate drain cycles.
        do_reset();
        drive(4'b0001, 1, 0, 0);
        cycle("bp_acc");
        fd_at = -1;
        for (int i = 0; i < 16; i++) begin
            fd_before = fd_seen;
            drive(4'b0000, 1, 1, (i % 2 == 0));
            cycle("bp");
            if (fd_seen != fd_before) fd_at = i;
        end
        chk("bp_fd_at", 256'(fd_at), 256'(14));
        drive(4'b0000, 1, 1, 1);
        cycle("bp_idle");

        // Async reset after beat 3 of a channel-1 frame.
        do_reset();
        drive(4'b0010, 1, 0, 0);
        cycle("ar_acc");
        drive(4'b0000, 1, 1, 1);
        repeat (3) cycle("ar_beat");
        fd_before = fd_seen;
        drive(4'b1010, 0, 1, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_chan_val", 256'(chan_val), 256'(0));
        chk("ar_frame_done", 256'(frame_done), 256'(0));
        chk("ar_grant", 256'(grant), 256'(4'b0010));
        chk("ar_ser_val", 256'(ser_val), 256'(1));
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        drive(4'b1010, 1, 0, 0);
        cycle("ar_regrant");
        drive(4'b0000, 1, 1, 1);
        repeat (9) cycle("ar_drain");
        chk("ar_fd_count", 256'(fd_seen - fd_before), 256'(1));

        // Serializer not ready: hold, then accept and wrap the pointer to 0.
        do_reset();
        drive(4'b1000, 0, 0, 0);
        repeat (3) cycle("wr_wait");
        drive(4'b1000, 1, 0, 0);
        cycle("wr_acc");
        drive(4'b0000, 1, 1, 1);
        repeat (8) cycle("wr_drain");
        drive(4'b1111, 1, 0, 0);
        @(negedge clk);
        chk("wr_grant", 256'(grant), 256'(4'b0001));
        @(posedge clk);
        model_step();
        #1;

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                for (int c = 0; c < int'(NR); c++)
                    for (int w = 0; w < int'(NS); w++) recv_msg[c][w] = $urandom;
            end
            drive(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 2) != 0));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
